// File: rtl/neuron_seq_ctrl_if.sv
// Handshake bundle between layer control (master) and the per-neuron pass sequencer (slave).
interface neuron_seq_ctrl_if #(
  parameter int unsigned BITS = 16
);
  logic            start;
  logic            train;
  logic            abort;
  logic            cfg_we;
  logic [BITS-1:0] cfg_lr;
  logic [BITS-1:0] y_in;
  logic            fp;
  logic            bp;
  logic [BITS-1:0] lr_out;
  logic [BITS-1:0] y_out;
  logic            y_valid;
  logic            busy;
  logic            done;
  logic [15:0]     pass_cnt;

  modport master (
    output start, train, abort, cfg_we, cfg_lr, y_in,
    input  fp, bp, lr_out, y_out, y_valid, busy, done, pass_cnt
  );

  modport slave (
    input  start, train, abort, cfg_we, cfg_lr, y_in,
    output fp, bp, lr_out, y_out, y_valid, busy, done, pass_cnt
  );
endinterface

// File: rtl/neuron_seq_ctrl.sv
// Forward/backward pass sequencer for one ReLU neuron; all outputs registered.
// Backward (training) pass is built only when NEURON_SEQ_TRAIN_EN is defined.
module neuron_seq_ctrl #(
  parameter int unsigned N      = 2,
  parameter int unsigned BITS   = 16,
  parameter int unsigned FP_LAT = (N + 1) / 2 + 4,
  parameter int unsigned BP_LAT = N + 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  neuron_seq_ctrl_if.slave   bus_io
);

  localparam logic [7:0]      FpLoad  = 8'(FP_LAT - 1);
  localparam logic [BITS-1:0] LrReset = BITS'(16'h0010);

`ifdef NEURON_SEQ_TRAIN_EN
  localparam logic [7:0] BpLoad = 8'(BP_LAT - 1);

  typedef enum logic [2:0] {StIdle, StFwd, StCapt, StBwd, StDone} state_e;

  logic train_q;
  logic bp_q;
`else
  typedef enum logic [1:0] {StIdle, StFwd, StCapt} state_e;
`endif

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic            fp_q;
  logic            y_valid_q;
  logic            done_q;
  logic            busy_q;
  logic [BITS-1:0] lr_q;
  logic [BITS-1:0] y_out_q;
  logic [15:0]     pass_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      fp_q       <= 1'b0;
      y_valid_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      lr_q       <= LrReset;
      y_out_q    <= '0;
      pass_cnt_q <= '0;
`ifdef NEURON_SEQ_TRAIN_EN
      train_q    <= 1'b0;
      bp_q       <= 1'b0;
`endif
    end else begin
      fp_q      <= 1'b0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef NEURON_SEQ_TRAIN_EN
      bp_q      <= 1'b0;
      // Rate is frozen for the whole backward pass.
      if (bus_io.cfg_we && (state_q != StBwd)) lr_q <= bus_io.cfg_lr;
`else
      if (bus_io.cfg_we) lr_q <= bus_io.cfg_lr;
`endif

      unique case (state_q)
        StIdle: begin
          if (bus_io.start && !bus_io.abort) begin
`ifdef NEURON_SEQ_TRAIN_EN
            train_q <= bus_io.train;
`endif
            cnt_q   <= FpLoad;
            fp_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StFwd;
          end
        end

        StFwd: begin
          if (bus_io.abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (cnt_q == 8'd0) begin
            y_out_q   <= bus_io.y_in;
            y_valid_q <= 1'b1;
            state_q   <= StCapt;
`ifdef NEURON_SEQ_TRAIN_EN
            if (!train_q) begin
              done_q     <= 1'b1;
              pass_cnt_q <= pass_cnt_q + 16'd1;
            end
`else
            done_q     <= 1'b1;
            pass_cnt_q <= pass_cnt_q + 16'd1;
`endif
          end else begin
            cnt_q <= cnt_q - 8'd1;
            fp_q  <= 1'b1;
          end
        end

        // Single low cycle between fp and bp guarantees a clean bp rising edge.
        StCapt: begin
`ifdef NEURON_SEQ_TRAIN_EN
          if (!bus_io.abort && train_q) begin
            cnt_q   <= BpLoad;
            bp_q    <= 1'b1;
            state_q <= StBwd;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
`else
          busy_q  <= 1'b0;
          state_q <= StIdle;
`endif
        end

`ifdef NEURON_SEQ_TRAIN_EN
        StBwd: begin
          if (bus_io.abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (cnt_q == 8'd0) begin
            done_q     <= 1'b1;
            pass_cnt_q <= pass_cnt_q + 16'd1;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q - 8'd1;
            bp_q  <= 1'b1;
          end
        end

        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
`endif

        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.fp       = fp_q;
`ifdef NEURON_SEQ_TRAIN_EN
  assign bus_io.bp       = bp_q;
`else
  assign bus_io.bp       = 1'b0;
`endif
  assign bus_io.lr_out   = lr_q;
  assign bus_io.y_out    = y_out_q;
  assign bus_io.y_valid  = y_valid_q;
  assign bus_io.busy     = busy_q;
  assign bus_io.done     = done_q;
  assign bus_io.pass_cnt = pass_cnt_q;

endmodule

// File: doc/neuron_seq_ctrl.md
# neuron_seq_ctrl

Pass sequencer for a single fixed-point ReLU neuron. On request it runs one forward pass and optionally one backward (training) pass, generating the `fp`/`bp` level strobes the neuron datapath needs. Each strobe rises from a low level and is held for a programmed cycle count. The block captures the neuron output, holds the learning-rate register, and reports completion. It sits between the layer-level control logic and each neuron instance, one controller per neuron.

## Interface
- `N`, 2, inputs per neuron; informational only, used in the default latencies.
- `BITS`, 16, data width in Q8.8 fixed point.
- `FP_LAT`, (N+1)/2+4, cycles `fp` is held high per forward pass; legal range 1..255.
- `BP_LAT`, N+3, cycles `bp` is held high per backward pass; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pass request; sampled only in IDLE.
- `train` in 1: sampled together with `start`; 1 means the forward pass is followed by a backward pass.
- `abort` in 1: cancels the pass in progress.
- `cfg_we` in 1: learning-rate write enable.
- `cfg_lr` in BITS: learning-rate write data.
- `y_in` in BITS: neuron output `y`.
- `fp` out 1: forward strobe to the neuron.
- `bp` out 1: backward strobe to the neuron.
- `lr_out` out BITS: learning rate to the neuron.
- `y_out` out BITS: captured forward result.
- `y_valid` out 1: one-cycle pulse; `y_out` has been updated.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at pass completion.
- `pass_cnt` out 16: count of completed passes.

## Operation
- States: IDLE, FWD, CAPT, BWD, DONE.
- All outputs are registered.
- Reset values: state IDLE; `fp`, `bp`, `y_valid`, `done`, `busy` = 0; `y_out` = 0; `pass_cnt` = 0; `lr_out` = 16'h0010 (0.0625).

State behaviour:
- **IDLE**
  - `start`=1 and `abort`=0: latch `train`, load the phase counter with FP_LAT-1, go to FWD.
  - `start` at any other time is ignored; it is not queued.
- **FWD**
  - `fp`=1 in every FWD cycle.
  - The phase counter decrements each cycle.
  - At counter 0: `y_out` <= `y_in` and go to CAPT.
- **CAPT**
  - Lasts 1 cycle; `fp`=0, `bp`=0, `y_valid`=1.
  - Latched train=0: `done`=1 in this cycle, `pass_cnt` increments, next state IDLE.
  - Latched train=1: load the counter with BP_LAT-1, next state BWD.
  - CAPT therefore provides the low cycle that guarantees a clean `bp` rising edge.
- **BWD**
  - `bp`=1 in every BWD cycle; the counter decrements.
  - At counter 0: go to DONE.
- **DONE**
  - Lasts 1 cycle; `bp`=0, `done`=1, `pass_cnt` increments, next state IDLE.

Rules that apply in every state:
- `fp` and `bp` are never high in the same cycle.
- Every pass begins with its strobe low for at least one cycle before it rises; IDLE always has `fp`=0.
- `pass_cnt` wraps from 16'hFFFF to 0.

Abort:
- `abort`=1 in FWD, CAPT or BWD: next state IDLE.
- `fp` and `bp` go low at the next edge.
- No `done` and no `pass_cnt` increment.
- `y_out` keeps its last value.
- Any `y_valid` or `done` that the current cycle's state would produce is suppressed.
- `abort` in DONE has no effect; the pass completes.
- `abort` in IDLE blocks `start` in the same cycle.

Learning rate:
- `cfg_we`=1: `lr_out` <= `cfg_lr`, in any state except BWD.
- A write that arrives during BWD is dropped, so the rate stays stable for the whole backward pass.
- Write and `rst` in the same cycle: reset wins.

## Timing
- `start` is sampled at edge E0; `fp`=1 for cycles E0+1 .. E0+FP_LAT.
- `y_out` is captured at edge E0+FP_LAT; `y_valid`=1 in cycle E0+FP_LAT+1.
- Inference: `done` is in the same cycle as `y_valid`.
  - `busy` is high for FP_LAT+1 cycles.
  - The next `start` can be accepted at edge E0+FP_LAT+2.
- Training: `bp`=1 for cycles E0+FP_LAT+2 .. E0+FP_LAT+BP_LAT+1.
  - `done` is in cycle E0+FP_LAT+BP_LAT+2.
- `rst` asserted mid-pass: at the next edge all outputs take their reset values, including `lr_out` and `pass_cnt`.

## Configuration
- `NEURON_SEQ_TRAIN_EN` defined: full behaviour as specified above.
- `NEURON_SEQ_TRAIN_EN` undefined:
  - `train` is ignored, BWD and DONE are not built, and `bp` is tied to 0.
  - Every pass ends in CAPT with `done`.
  - `lr_out` and the `cfg_*` ports remain, and a write is accepted in any state.

## Test plan
- Reset, then check idle outputs → `lr_out`=16'h0010, `pass_cnt`=0, `fp`=`bp`=`busy`=0.
- FP_LAT=5, `y_in`=16'h0180, `start` with train=0 → `fp` high for exactly 5 cycles; then one cycle with `y_valid`=`done`=1 and `y_out`=16'h0180; `pass_cnt`=1.
- Training pass (FP_LAT=5, BP_LAT=5) with `cfg_we` pulsed during BWD carrying 16'h0020 → `bp` low for one cycle after `fp`, then high for 5 cycles; `done` 12 cycles after `start`; `lr_out` unchanged.
- `abort` in the 3rd FWD cycle → `fp` low next cycle; no `done`; `pass_cnt` unchanged; new `start` accepted in the following IDLE cycle.
- `start` pulses while busy, and `start`+`abort` together in IDLE → both ignored; exactly one pass completes.
- Preload `pass_cnt` to 16'hFFFF via 65535 passes, or force it in the bench; complete one more pass → `pass_cnt`=0.
